// File: rtl/register_bank_pipe_if.sv
//------------------------------------------------------------------------------
// Module      : register_bank_pipe_if
// Description : Valid/ready handshake bundle for the register bank pipeline:
//               an upstream (in_*) side and a downstream (out_*) side.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface register_bank_pipe_if #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4
);
  localparam int BUS_W = WIDTH * CHANNELS;

  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BUS_W-1:0] out_data;

  // Master drives the upstream word and the downstream ready.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/register_bank_pipe.sv
//------------------------------------------------------------------------------
// Module      : register_bank_pipe
// Description : CHANNELS x WIDTH register bank carried through a DEPTH-stage
//               elastic, flushable, back-pressured pipeline.
//               Optional feature macro: REG_BANK_OCC_EN (occupancy port).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module register_bank_pipe #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              en,
  input  wire logic              flush,
  register_bank_pipe_if.slave    bus
`ifdef REG_BANK_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  localparam int BUS_W = WIDTH * CHANNELS;

  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][BUS_W-1:0] d_q, d_d;
  logic [DEPTH-1:0]            rdy;
  logic [DEPTH-1:0]            up_v;
  logic [DEPTH-1:0][BUS_W-1:0] up_d;
  logic                        rdy_run;

  // A stage can load when anything at or downstream of it can make room.
  always_comb begin
    rdy_run = bus.out_ready;
    rdy     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy_run = rdy_run | ~v_q[i];
      rdy[i]  = rdy_run;
    end
  end

  always_comb begin
    up_v    = '0;
    up_d    = '0;
    up_v[0] = bus.in_valid;
    up_d[0] = bus.in_data;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = v_q[i-1];
      up_d[i] = d_q[i-1];
    end
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (en) begin
      if (flush) begin
        v_d = '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (rdy[i]) begin
            v_d[i] = up_v[i];
            if (up_v[i]) begin
              d_d[i] = up_d[i];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q <= '0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign bus.in_ready  = rst & en & ~flush & rdy[0];
  assign bus.out_valid = rst & en & v_q[DEPTH-1];
  assign bus.out_data  = rst ? d_q[DEPTH-1] : '0;

`ifdef REG_BANK_OCC_EN
  localparam int OCC_W = $clog2(DEPTH + 1);
  logic [OCC_W-1:0] occ_sum;

  // Occupancy follows the valid bits even while frozen by en.
  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_sum = occ_sum + {{(OCC_W-1){1'b0}}, v_q[i]};
    end
  end

  assign occupancy = rst ? occ_sum : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_register_bank_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_register_bank_pipe
// Description : Directed self-checking bench for register_bank_pipe
//               (WIDTH=5, CHANNELS=4, DEPTH=2).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_register_bank_pipe;

  localparam int WIDTH    = 5;
  localparam int CHANNELS = 4;
  localparam int DEPTH    = 2;
  localparam int BUS_W    = WIDTH * CHANNELS;

  logic clk;
  logic rst;
  logic en;
  logic flush;
  int   checks;
  int   failures;

  register_bank_pipe_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

`ifdef REG_BANK_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

  register_bank_pipe #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS),
    .DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .bus      (bus.slave)
`ifdef REG_BANK_OCC_EN
    ,
    .occupancy(occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change 1ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [BUS_W-1:0] id, input logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 20'hABCDE, 1'b1);
    cyc();
    drive(1'b1, 20'hABCDE, 1'b1);
    cyc();
    drive(1'b1, 20'h12345, 1'b1);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== 20'h0) begin
      failures++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data);
    end
`ifdef REG_BANK_OCC_EN
    checks++;
    if (occupancy !== 2'd0) begin
      failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy);
    end
`endif
    rst = 1'b1;
    drive(1'b0, 20'h0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_idle out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready);
    end
    cyc();
  endtask

  task automatic test_streaming();
    logic [BUS_W-1:0] exp_d;
    for (int j = 0; j < 6; j++) begin
      drive(j < 3, BUS_W'(j + 1), 1'b1);
      if (j < 3) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          failures++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", j, bus.in_ready);
        end
      end
      checks++;
      if (bus.out_valid !== (j >= 2 && j <= 4)) begin
        failures++; $display("FAIL stream_out_valid cyc=%0d got=%b", j, bus.out_valid);
      end
      if (j >= 2 && j <= 4) begin
        exp_d = BUS_W'(j - 1);
        checks++;
        if (bus.out_data !== exp_d) begin
          failures++; $display("FAIL stream_out_data cyc=%0d got=%h exp=%h", j, bus.out_data, exp_d);
        end
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 20'h0000A, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_accept_a got=%b exp=1", bus.in_ready);
    end
    cyc();
    drive(1'b1, 20'h0000B, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_accept_b got=%b exp=1", bus.in_ready);
    end
    cyc();
    drive(1'b1, 20'h0000C, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_full_in_ready got=%b exp=0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 20'h0000A) begin
      failures++; $display("FAIL bp_full_head got=%b/%h exp=1/0000a", bus.out_valid, bus.out_data);
    end
`ifdef REG_BANK_OCC_EN
    checks++;
    if (occupancy !== 2'd2) begin
      failures++; $display("FAIL bp_occupancy got=%0d exp=2", occupancy);
    end
`endif
    cyc();
    // Stalled cycle must not have moved anything.
    drive(1'b1, 20'h0000C, 1'b1);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_data !== 20'h0000A) begin
      failures++; $display("FAIL bp_release in_ready=%b out=%h exp 1/0000a", bus.in_ready, bus.out_data);
    end
    cyc();
    drive(1'b0, 20'h0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 20'h0000B) begin
      failures++; $display("FAIL bp_drain_b got=%b/%h exp=1/0000b", bus.out_valid, bus.out_data);
    end
    cyc();
    drive(1'b0, 20'h0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 20'h0000C) begin
      failures++; $display("FAIL bp_drain_c got=%b/%h exp=1/0000c", bus.out_valid, bus.out_data);
    end
    cyc();
    drive(1'b0, 20'h0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL bp_empty got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 20'h00011, 1'b0);
    cyc();
    drive(1'b1, 20'h00012, 1'b0);
    cyc();
    flush = 1'b1;
    drive(1'b1, 20'h000FF, 1'b1);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready);
    end
    cyc();
    flush = 1'b0;
    drive(1'b0, 20'h0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid);
    end
`ifdef REG_BANK_OCC_EN
    checks++;
    if (occupancy !== 2'd0) begin
      failures++; $display("FAIL flush_occupancy got=%0d exp=0", occupancy);
    end
`endif
    cyc();
    drive(1'b0, 20'h0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_dropped_word got=%b/%h exp=0", bus.out_valid, bus.out_data);
    end
    cyc();
  endtask

  task automatic test_enable();
    drive(1'b1, 20'h00021, 1'b0);
    cyc();
    drive(1'b1, 20'h00022, 1'b0);
    cyc();
    en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 20'h000EE, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL en_freeze cyc=%0d out_valid=%b in_ready=%b exp 0/0", j, bus.out_valid, bus.in_ready);
      end
`ifdef REG_BANK_OCC_EN
      checks++;
      if (occupancy !== 2'd2) begin
        failures++; $display("FAIL en_occupancy cyc=%0d got=%0d exp=2", j, occupancy);
      end
`endif
      cyc();
    end
    en = 1'b1;
    drive(1'b0, 20'h0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 20'h00021) begin
      failures++; $display("FAIL en_resume_1 got=%b/%h exp=1/00021", bus.out_valid, bus.out_data);
    end
    cyc();
    drive(1'b0, 20'h0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 20'h00022) begin
      failures++; $display("FAIL en_resume_2 got=%b/%h exp=1/00022", bus.out_valid, bus.out_data);
    end
    cyc();
    drive(1'b0, 20'h0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL en_resume_empty got=%b exp=0", bus.out_valid);
    end
  endtask

  task automatic test_lanes();
    logic [BUS_W-1:0] lanes;
    lanes = {5'd4, 5'd3, 5'd2, 5'd1};
    drive(1'b1, lanes, 1'b1);
    cyc();
    drive(1'b0, 20'h0, 1'b1);
    cyc();
    drive(1'b0, 20'h0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 20'h20C41) begin
      failures++; $display("FAIL lanes_word got=%b/%h exp=1/20c41", bus.out_valid, bus.out_data);
    end
    for (int c = 0; c < CHANNELS; c++) begin
      checks++;
      if (bus.out_data[c*WIDTH +: WIDTH] !== WIDTH'(c + 1)) begin
        failures++;
        $display("FAIL lane_%0d got=%0d exp=%0d", c, bus.out_data[c*WIDTH +: WIDTH], c + 1);
      end
    end
    cyc();
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 20'h00031, 1'b0);
    cyc();
    drive(1'b1, 20'h00032, 1'b0);
    cyc();
    rst = 1'b0;
    drive(1'b0, 20'h0, 1'b1);
    cyc();
    rst = 1'b1;
    drive(1'b1, 20'h00033, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 20'h0) begin
      failures++; $display("FAIL midreset_cleared got=%b/%h exp=0/0", bus.out_valid, bus.out_data);
    end
    cyc();
    drive(1'b0, 20'h0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL midreset_latency got=%b exp=0", bus.out_valid);
    end
    cyc();
    drive(1'b0, 20'h0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 20'h00033) begin
      failures++; $display("FAIL midreset_first_word got=%b/%h exp=1/00033", bus.out_valid, bus.out_data);
    end
    cyc();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    en            = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_enable();
    test_lanes();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
